// File: rtl/mult_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mult_seq                                                           |
// | Brief  : Parametrised sequential shift-add multiplier, WIDTH+3 cycles/op.   |
// |          Define MULT_SEQ_SIGNED_EN for two's-complement operands.           |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module mult_seq #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset_l,
   input  logic                 start,
   input  logic [WIDTH-1:0]     mcand,
   input  logic [WIDTH-1:0]     mplier,
   output logic                 rdy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [2*WIDTH-1:0] r_mcand_ext;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_acc;
   logic [CNT_W-1:0]   r_cnt;

   logic [2*WIDTH-1:0] w_mcand_ext;
   logic [2*WIDTH-1:0] w_addend;
   logic [2*WIDTH-1:0] w_acc_step;
   logic               w_last;
   logic               w_sub;

   assign w_last = (r_cnt == c_last);

`ifdef MULT_SEQ_SIGNED_EN
   // Multiplier MSB carries weight -2^(WIDTH-1), hence the final subtract.
   assign w_mcand_ext = {{WIDTH{mcand[WIDTH-1]}}, mcand};
   assign w_sub       = w_last;
`else
   assign w_mcand_ext = {{WIDTH{1'b0}}, mcand};
   assign w_sub       = 1'b0;
`endif

   assign w_addend   = r_mcand_ext << r_cnt;
   assign w_acc_step = !r_mplier[0] ? r_acc :
                       w_sub        ? (r_acc - w_addend) : (r_acc + w_addend);

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l)
         r_state <= S_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      rdy          = 1'b0;
      done         = 1'b0;
      case (r_state)
         S_IDLE: begin
            rdy = 1'b1;
            if (start)
               w_state_next = S_LOAD;
         end
         S_LOAD: w_state_next = S_RUN;
         S_RUN: begin
            if (w_last)
               w_state_next = S_DONE;
         end
         S_DONE: begin
            done         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Operands are captured on the accept edge itself so later input changes
   // cannot leak into the operation.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         r_mcand_ext <= '0;
         r_mplier    <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         product     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mcand_ext <= w_mcand_ext;
                  r_mplier    <= mplier;
               end
            end
            S_LOAD: begin
               r_acc <= '0;
               r_cnt <= '0;
            end
            S_RUN: begin
               r_acc    <= w_acc_step;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + CNT_W'(1);
               // Result registered on the final step so it is valid alongside done.
               if (w_last)
                  product <= w_acc_step;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mult_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_mult_seq                                                        |
// | Brief  : Self-checking bench for mult_seq (table, corner sequences, random) |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_mult_seq;

   localparam int WIDTH   = 8;
   localparam int LAT     = WIDTH + 2;   // negedges from accept edge to done cycle
   localparam int TIMEOUT = 60;

   logic                clk;
   logic                reset_l;
   logic                start;
   logic [WIDTH-1:0]    mcand;
   logic [WIDTH-1:0]    mplier;
   logic                rdy;
   logic                done;
   logic [2*WIDTH-1:0]  product;

   int n_cmp  = 0;
   int n_fail = 0;

   mult_seq #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .reset_l (reset_l),
      .start   (start),
      .mcand   (mcand),
      .mplier  (mplier),
      .rdy     (rdy),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0]   a;
      logic [WIDTH-1:0]   b;
      logic [2*WIDTH-1:0] exp;
   } vec_t;

   function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
      longint p;
`ifdef MULT_SEQ_SIGNED_EN
      p = longint'($signed(a)) * longint'($signed(b));
`else
      p = longint'({1'b0, a}) * longint'({1'b0, b});
`endif
      return p[2*WIDTH-1:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_rdy();
      int t = 0;
      while (!rdy && t < TIMEOUT) begin
         @(negedge clk);
         t++;
      end
      if (!rdy) check("rdy_timeout", 32'(rdy), 32'd1);
   endtask

   // One full operation; checks latency, product, hold of old product and rdy return.
   task automatic do_op(input string name, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [2*WIDTH-1:0] exp);
      int               cycles;
      logic [2*WIDTH-1:0] prev;
      logic             held;
      wait_rdy();
      prev   = product;
      start  = 1'b1;
      mcand  = a;
      mplier = b;
      @(posedge clk);
      @(negedge clk);
      start  = 1'b0;
      mcand  = WIDTH'($urandom);
      mplier = WIDTH'($urandom);
      cycles = 1;
      held   = 1'b1;
      while (!done && cycles < TIMEOUT) begin
         if (product !== prev || rdy) held = 1'b0;
         @(negedge clk);
         cycles++;
      end
      check({name, "_latency"}, 32'(cycles), 32'(LAT));
      check({name, "_product"}, 32'(product), 32'(exp));
      check({name, "_hold_busy"}, 32'(held), 32'd1);
      @(negedge clk);
      check({name, "_rdy_after"}, {30'd0, rdy, done}, 32'b10);
   endtask

   vec_t vecs[6];

   initial begin
      int n_done;
      int n_acc;
      int t_done[$];
      logic [2*WIDTH-1:0] p_done[$];
      logic [WIDTH-1:0] ra, rb;

`ifdef MULT_SEQ_SIGNED_EN
      vecs[0] = '{8'hFD, 8'h05, 16'hFFF1};
      vecs[1] = '{8'h80, 8'h80, 16'h4000};
      vecs[2] = '{8'h7F, 8'hFF, 16'hFF81};
      vecs[3] = '{8'h00, 8'hC8, 16'h0000};
      vecs[4] = '{8'h7F, 8'h7F, 16'h3F01};
      vecs[5] = '{8'hFF, 8'hFF, 16'h0001};
`else
      vecs[0] = '{8'd3,   8'd5,   16'd15};
      vecs[1] = '{8'd255, 8'd255, 16'hFE01};
      vecs[2] = '{8'd0,   8'd200, 16'd0};
      vecs[3] = '{8'd128, 8'd2,   16'd256};
      vecs[4] = '{8'd1,   8'd1,   16'd1};
      vecs[5] = '{8'd200, 8'd0,   16'd0};
`endif

      start   = 1'b0;
      mcand   = '0;
      mplier  = '0;
      reset_l = 1'b1;
      #1 reset_l = 1'b0;
      #1;
      check("reset_idle_clk", {15'd0, rdy, done, product}, {15'd0, 1'b1, 1'b0, 16'd0});
      repeat (3) @(negedge clk);
      reset_l = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++)
         do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp);

      // Start pulses during RUN must be ignored.
      wait_rdy();
      start = 1'b1; mcand = 8'd7; mplier = 8'd9;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1; mcand = 8'd2; mplier = 8'd2;
      @(negedge clk);
      start = 1'b0;
      n_done = 0;
      for (int i = 0; i < 25; i++) begin
         if (done) begin
            n_done++;
            check("busy_product", 32'(product), 32'(ref_mul(8'd7, 8'd9)));
         end
         @(negedge clk);
      end
      check("busy_done_count", 32'(n_done), 32'd1);
      do_op("after_busy", 8'd6, 8'd4, ref_mul(8'd6, 8'd4));

      // Start held high: two back-to-back accepts, operands swapped after the first.
      wait_rdy();
      start = 1'b1; mcand = 8'hFD; mplier = 8'h05;
      n_acc = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) begin
            t_done.push_back(i);
            p_done.push_back(product);
         end
         if (rdy && start) begin
            n_acc++;
            @(negedge clk);
            if (n_acc == 1) begin
               mcand = 8'h80; mplier = 8'h80;
            end else begin
               start = 1'b0;
            end
         end else begin
            @(negedge clk);
         end
      end
      check("b2b_done_count", 32'(t_done.size()), 32'd2);
      if (t_done.size() == 2) begin
         check("b2b_first", 32'(p_done[0]), 32'(ref_mul(8'hFD, 8'h05)));
         check("b2b_second", 32'(p_done[1]), 32'(ref_mul(8'h80, 8'h80)));
         check("b2b_spacing", 32'(t_done[1] - t_done[0]), 32'(WIDTH + 3));
      end

      // Asynchronous reset at RUN step 3.
      wait_rdy();
      start = 1'b1; mcand = 8'd12; mplier = 8'd12;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2 reset_l = 1'b0;
      #1;
      check("midrun_reset", {15'd0, rdy, done, product}, {15'd0, 1'b1, 1'b0, 16'd0});
      @(negedge clk);
      reset_l = 1'b1;
      n_done = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      check("midrun_no_done", 32'(n_done), 32'd0);
      check("midrun_product", 32'(product), 32'd0);

      for (int i = 0; i < 20; i++) begin
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         if (i == 0) rb = '0;
         do_op($sformatf("rand%0d", i), ra, rb, ref_mul(ra, rb));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
